uart_rx_buffered: RTL and testbench
===================================

Name: uart_rx_buffered

Overview:
- UART receive path for the Grande_Risco_5 SoC peripheral bus. Recovers 8N1 frames from the asynchronous `rx` pin.
- Received bytes go into a FIFO of `BUFFER_SIZE` entries. Overrun and framing errors are reported as sticky flags.
- Sits between the `rx` pad and the UART register interface, which reads bytes with single-cycle `rd_en` pops.

Parameters:
- CLOCK_FREQ, 50_000_000, system clock in Hz.
- BAUD_RATE, 115200, line rate in bit/s. CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE, integer-truncated; 434 at defaults.
- BUFFER_SIZE, 16, FIFO depth. Must be a power of two and ≥ 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset (asserted asynchronously).
- rx  input  1  serial line, idle high, asynchronous to clk.
- rd_en  input  1  pop request; ignored when empty.
- rd_data  output  8  FIFO head byte; valid while `!empty`.
- empty  output  1  FIFO holds 0 bytes.
- full  output  1  FIFO holds BUFFER_SIZE bytes.
- count  output  $clog2(BUFFER_SIZE)+1  current occupancy.
- clr_err  input  1  one-cycle pulse; clears both error flags.
- overrun_err  output  1  sticky: a byte was lost because the FIFO was full.
- frame_err  output  1  sticky: a stop bit was sampled low.

Behaviour:
- Reset (`rst_n` low): state IDLE, `empty`=1, `full`=0, `count`=0, `rd_data`=0, both error flags 0. Synchronizer flops reset to 1.
- `rx` passes through a 2-flop synchronizer, `rx_s`. All sampling uses `rx_s`.
- FSM states: IDLE, START, DATA, STOP, plus PARITY when enabled.
  - IDLE: on `rx_s`=0 go to START; bit counter cleared.
  - START: wait CLKS_PER_BIT/2 cycles (217 at defaults), then resample. If 0, go to DATA. If 1, treat as a glitch and return to IDLE; no error is raised.
  - DATA: sample every CLKS_PER_BIT cycles. Bits are shifted LSB first. After bit 7 is sampled, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If 1: push the byte to the FIFO.
    - If 0: set `frame_err`, discard the byte, and wait for `rx_s`=1 before entering IDLE. This prevents a break condition from retriggering reception.
- Push timing: the byte is written on the stop-sample cycle and becomes visible on `rd_data`/`count` the next cycle. Latency is 1 cycle after the stop sample.
- FIFO: circular buffer. Pointers are $clog2(BUFFER_SIZE) bits and wrap naturally. `rd_data` always reflects mem[rd_ptr] (first-word fall-through).
- Pop with `rd_en`=1 and `!empty`: rd_ptr advances and `count` decrements on the next edge.
- Push and pop in the same cycle:
  - Both succeed; `count` is unchanged.
  - If full, the push is accepted because a slot is freed in that cycle; no overrun.
- Push while full with no pop: byte dropped, `overrun_err` set, FIFO contents unchanged.
- Pop while empty: no effect; `count` stays 0.
- `clr_err` in the same cycle as a new error event: the set wins and the flag reads 1.
- Reset mid-frame returns the block to IDLE and flushes the FIFO. A partial frame is discarded.
- After STOP, the block re-arms on the very next cycle, so back-to-back frames with zero idle are received.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP and samples 1 bit after bit 7.
  - Even parity is checked over the data plus parity bit.
  - Output port `parity_err` (1 bit, sticky, reset 0, cleared by `clr_err`) is added. On mismatch it sets and the byte is discarded after STOP.
- Not defined: no PARITY state, no `parity_err` port; pure 8N1.

Test Plan:
- Default params, send 0xA5 at 434 clk/bit → `empty` deasserts 1 cycle after the stop sample, `rd_data`=0xA5, `count`=1. Pulse `rd_en` → `empty`=1, `count`=0.
- Send 16 bytes 0x00..0x0F back-to-back → `full`=1, `count`=16. Send 0xFF → `overrun_err`=1 and the FIFO is unchanged. Popping 16 times yields 0x00..0x0F in order.
- With the FIFO full, assert `rd_en` on the 17th byte's stop-sample cycle → no overrun, `count` stays 16, last entry is the 17th byte. Then drain all 16 and check pointer wrap across a second fill of 0x10..0x1F.
- Frame 0x3C with stop bit held low for 2 bit times → `frame_err`=1, FIFO empty. Next valid 0x55 is received correctly. `clr_err` clears `frame_err`.
- 100-cycle low glitch on `rx` → back to IDLE, no byte, no error. Assert `rst_n`=0 mid-data bit 4 → all outputs at reset values; a following 0x81 is received correctly.
- With UART_RX_PARITY_EN: 0x07 sent with parity 1 → accepted. 0x07 sent with parity 0 → `parity_err`=1, FIFO empty.

Source files
------------

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered
//
// Purpose: 8N1 UART receiver with a first-word-fall-through receive FIFO and
// sticky error flags. The rx pin is synchronised with two flops and sampled
// near the middle of each bit. Timing comes from a down-counter that is
// reloaded and compared against zero (terminal count).
//
// Optional build macro: UART_RX_PARITY_EN. It adds even-parity checking and
// the parity_err output.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rx           serial input (idle high, asynchronous to clk)
//   rd_en        pop request for the FIFO head (ignored when empty)
//   rd_data      FIFO head byte, valid while !empty
//   empty/full   FIFO occupancy status
//   count        FIFO occupancy, 0..BUFFER_SIZE
//   clr_err      one-cycle pulse that clears the sticky error flags
//   overrun_err  sticky: a byte was dropped because the FIFO was full
//   frame_err    sticky: a stop bit was sampled low
//   parity_err   sticky: parity mismatch (UART_RX_PARITY_EN builds only)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line idle, waiting for rx_s low
// S_START  | half-bit wait, then confirm the start bit (high = glitch)
// S_DATA   | sample 8 data bits LSB first, one per bit period
// S_PARITY | sample the parity bit (UART_RX_PARITY_EN only)
// S_STOP   | sample the stop bit; after a low stop, hold until rx_s is high

module uart_rx_buffered #(
    parameter int CLOCK_FREQ  = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int BUFFER_SIZE = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(BUFFER_SIZE):0]  count,
    input  logic                          clr_err,
    output logic                          overrun_err,
    output logic                          frame_err
`ifdef UART_RX_PARITY_EN
    ,output logic                         parity_err
`endif
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam int PW = $clog2(BUFFER_SIZE);
    localparam int CW = PW + 1;
    localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_RX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    logic            rx_meta_q, rx_s_q;
    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            brk_q, brk_d;
    logic            timer_tc;
    logic            push_req;
    logic            frame_set;
    logic            par_bad;

`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            parity_set;
    logic            parity_err_q;
    assign par_bad = par_bad_q;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign timer_tc = (timer_q == '0);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        brk_d     = brk_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        parity_set = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                brk_d     = 1'b0;
                bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (!rx_s_q) begin
                    state_d = S_START;
                    timer_d = HALF_RELOAD;
                end
            end
            S_START: begin
                if (!timer_tc) begin
                    timer_d = timer_q - 1'b1;
                end else if (!rx_s_q) begin
                    state_d = S_DATA;
                    timer_d = BIT_RELOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!timer_tc) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    timer_d   = BIT_RELOAD;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!timer_tc) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    // Even parity: data plus parity bit must XOR to zero.
                    par_bad_d  = ^{shift_q, rx_s_q};
                    parity_set = ^{shift_q, rx_s_q};
                    timer_d    = BIT_RELOAD;
                    state_d    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // After a low stop bit, hold here until the line returns high
                // so that a break cannot start a new frame.
                if (brk_q) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end else if (!timer_tc) begin
                    timer_d = timer_q - 1'b1;
                end else if (rx_s_q) begin
                    push_req = !par_bad;
                    state_d  = S_IDLE;
                end else begin
                    frame_set = 1'b1;
                    brk_d     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            brk_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            brk_q     <= brk_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Receive FIFO
    logic [7:0]    mem_q [BUFFER_SIZE];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, overrun_set;
    logic          overrun_q, frame_q;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(BUFFER_SIZE));
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign pop  = rd_en && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted in that case.
    assign push        = push_req && (!full || pop);
    assign overrun_set = push_req && full && !pop;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Sticky flags: a new event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            overrun_q <= overrun_set | (overrun_q & ~clr_err);
            frame_q   <= frame_set | (frame_q & ~clr_err);
        end
    end

    assign overrun_err = overrun_q;
    assign frame_err   = frame_q;

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_set | (parity_err_q & ~clr_err);
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Testbench for uart_rx_buffered with scoreboard-based FIFO checking.
// The bench uses a reduced bit period of 16 clocks to keep the run short.
module tb_uart_rx_buffered;

    localparam int CF      = 1_600_000;
    localparam int BR      = 100_000;
    localparam int BS      = 16;
    localparam int C       = CF / BR;
    // Clock offset within the stop bit of the DUT stop-sample cycle:
    // two synchroniser flops plus the half-bit start wait.
    localparam int POP_OFS = 2 + C / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic stim_rd = 1'b0;
    logic mon_rd = 1'b0;
    logic clr_err = 1'b0;
    logic rd_en;
    logic [7:0] rd_data;
    logic empty, full;
    logic [$clog2(BS):0] count;
    logic overrun_err, frame_err;
`ifdef UART_RX_PARITY_EN
    logic parity_err;
    bit   par_flip = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    bit drain_en = 1'b0;
    logic lat_e0, lat_e1;
    logic [7:0] lat_head;
    logic [7:0] mon_exp;
    logic [7:0] head_exp;

    assign rd_en = stim_rd | mon_rd;

    uart_rx_buffered #(
        .CLOCK_FREQ (CF),
        .BAUD_RATE  (BR),
        .BUFFER_SIZE(BS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .clr_err    (clr_err),
        .overrun_err(overrun_err),
        .frame_err  (frame_err)
`ifdef UART_RX_PARITY_EN
        ,.parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic send_byte(input logic [7:0] d, input bit pop_at_stop,
                             input bit clr_at_stop, input int stop_low);
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (C) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (C) @(negedge clk);
`endif
        if (stop_low > 0) begin
            rx = 1'b0;
            repeat (C * stop_low) @(negedge clk);
            rx = 1'b1;
            repeat (C) @(negedge clk);
        end else begin
            rx = 1'b1;
            for (int j = 0; j < C; j++) begin
                if (j == POP_OFS) begin
                    lat_e0   = empty;
                    lat_head = rd_data;
                    if (pop_at_stop) stim_rd = 1'b1;
                    if (clr_at_stop) clr_err = 1'b1;
                end
                if (j == POP_OFS + 1) lat_e1 = empty;
                @(negedge clk);
                stim_rd = 1'b0;
                clr_err = 1'b0;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        drain_en = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if (exp_q.size() == 0 && empty && !mon_rd) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({name, "_drain_done"}, 32'(done), 32'd1);
        drain_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: pops whenever the FIFO presents a byte and draining is enabled.
    always @(negedge clk) begin
        if (mon_rd) begin
            mon_rd = 1'b0;
        end else if (drain_en && !empty) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor_unexpected: got %0h expected no byte", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rd_data !== mon_exp) begin
                    errors++;
                    $display("FAIL monitor_byte: got %0h expected %0h", rd_data, mon_exp);
                end
            end
            mon_rd = 1'b1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_overrun", 32'(overrun_err), 32'd0);
        chk("rst_frame", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single byte and push latency
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b0, 1'b0, 0);
        chk("lat_empty_at_stop", 32'(lat_e0), 32'd1);
        chk("lat_empty_after", 32'(lat_e1), 32'd0);
        chk("a5_rd_data", 32'(rd_data), 32'hA5);
        chk("a5_count", 32'(count), 32'd1);
        wait_drain("a5");
        chk("a5_empty_after_pop", 32'(empty), 32'd1);
        chk("a5_count_after_pop", 32'(count), 32'd0);
        stim_rd = 1'b1;
        @(negedge clk);
        stim_rd = 1'b0;
        @(negedge clk);
        chk("pop_empty_count", 32'(count), 32'd0);
        chk("pop_empty_empty", 32'(empty), 32'd1);

        // Fill, overrun with simultaneous clear, drain
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b0, 1'b0, 0);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        send_byte(8'hFF, 1'b0, 1'b1, 0);
        chk("overrun_set_wins", 32'(overrun_err), 32'd1);
        chk("overrun_count", 32'(count), 32'd16);
        chk("overrun_head", 32'(rd_data), 32'(exp_q[0]));
        pulse_clr();
        chk("overrun_cleared", 32'(overrun_err), 32'd0);
        wait_drain("fill1");

        // Full FIFO with pop on the stop-sample cycle
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(8'h20 + i));
            send_byte(8'(8'h20 + i), 1'b0, 1'b0, 0);
        end
        chk("fill2_full", 32'(full), 32'd1);
        head_exp = exp_q.pop_front();
        exp_q.push_back(8'h30);
        send_byte(8'h30, 1'b1, 1'b0, 0);
        chk("pushpop_head", 32'(lat_head), 32'(head_exp));
        chk("pushpop_overrun", 32'(overrun_err), 32'd0);
        chk("pushpop_count", 32'(count), 32'd16);
        wait_drain("pushpop");

        // Second fill across the pointer wrap
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(8'h10 + i));
            send_byte(8'(8'h10 + i), 1'b0, 1'b0, 0);
        end
        chk("wrap_count", 32'(count), 32'd16);
        wait_drain("wrap");

        // Framing error with a break, then recovery
        send_byte(8'h3C, 1'b0, 1'b0, 2);
        repeat (C) @(negedge clk);
        chk("frame_set", 32'(frame_err), 32'd1);
        chk("frame_empty", 32'(empty), 32'd1);
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b0, 1'b0, 0);
        wait_drain("after_frame");
        chk("frame_sticky", 32'(frame_err), 32'd1);
        pulse_clr();
        chk("frame_cleared", 32'(frame_err), 32'd0);

        // Short low glitch is ignored
        rx = 1'b0;
        repeat (C / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * C) @(negedge clk);
        chk("glitch_empty", 32'(empty), 32'd1);
        chk("glitch_frame", 32'(frame_err), 32'd0);
        chk("glitch_overrun", 32'(overrun_err), 32'd0);

        // Reset in the middle of data bit 4 flushes the FIFO
        exp_q.push_back(8'h99);
        send_byte(8'h99, 1'b0, 1'b0, 0);
        chk("pre_reset_count", 32'(count), 32'd1);
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (C) @(negedge clk);
        end
        rx = 1'b0;
        repeat (C / 2) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_rd_data", 32'(rd_data), 32'd0);
        chk("midrst_full", 32'(full), 32'd0);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b0, 1'b0, 0);
        chk("post_rst_count", 32'(count), 32'd1);
        wait_drain("post_rst");

`ifdef UART_RX_PARITY_EN
        exp_q.push_back(8'h07);
        send_byte(8'h07, 1'b0, 1'b0, 0);
        chk("par_ok_err", 32'(parity_err), 32'd0);
        wait_drain("par_ok");
        par_flip = 1'b1;
        send_byte(8'h07, 1'b0, 1'b0, 0);
        par_flip = 1'b0;
        chk("par_bad_err", 32'(parity_err), 32'd1);
        chk("par_bad_empty", 32'(empty), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
